// File: rtl/button_counter.sv
// button_counter: two debounced pushbuttons step an 8-bit up/down counter shown on LED0..LED7.
module button_counter #(
   parameter int N = 16,
   parameter int DB_SAMPLES = 4,
   parameter logic [7:0] INIT = 8'h00
) (
   input  logic CLK,
   input  logic RSTN,
   input  logic SW1,
   input  logic SW2,
   output logic LED0,
   output logic LED1,
   output logic LED2,
   output logic LED3,
   output logic LED4,
   output logic LED5,
   output logic LED6,
   output logic LED7,
   output logic D13
);
   typedef enum logic [1:0] {RELEASED, PRESSING, PRESSED, RELEASING} state_t;
   localparam logic [N-1:0] ONE = 1;
   localparam logic [3:0] DB = DB_SAMPLES[3:0];
   localparam bit SINGLE = DB_SAMPLES == 1;
   logic [N-1:0] pre;
   logic tick;
   logic [1:0] sw, press, held;
   logic [7:0] value;
   assign tick = &pre;
   assign sw = {SW2, SW1};
   assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = value;
   always_ff @(posedge CLK or negedge RSTN)
      if (!RSTN) pre <= '0;
      else pre <= pre + ONE;
   for (genvar g = 0; g < 2; g++) begin : db
      state_t st;
      logic [3:0] cnt, nxt;
      logic [1:0] sy;
      logic s, pr;
      assign s = sy[1];
      assign nxt = cnt + 4'd1;
      assign held[g] = st == PRESSED;
      assign press[g] = pr;
      // a return to PRESSED from RELEASING is a rejected release glitch, not a new press
      always_ff @(posedge CLK or negedge RSTN)
         if (!RSTN) begin
            sy <= 2'b00;
            st <= RELEASED;
            cnt <= 4'd0;
            pr <= 1'b0;
         end else begin
            sy <= {sy[0], sw[g]};
            pr <= 1'b0;
            if (tick)
               case (st)
                  RELEASED: if (s) begin
                     st <= SINGLE ? PRESSED : PRESSING;
                     cnt <= SINGLE ? 4'd0 : 4'd1;
                     pr <= SINGLE;
                  end
                  PRESSING: if (!s) begin
                     st <= RELEASED;
                     cnt <= 4'd0;
                  end else if (nxt == DB) begin
                     st <= PRESSED;
                     cnt <= 4'd0;
                     pr <= 1'b1;
                  end else cnt <= nxt;
                  PRESSED: if (!s) begin
                     st <= SINGLE ? RELEASED : RELEASING;
                     cnt <= SINGLE ? 4'd0 : 4'd1;
                  end
                  RELEASING: if (s) begin
                     st <= PRESSED;
                     cnt <= 4'd0;
                  end else if (nxt == DB) begin
                     st <= RELEASED;
                     cnt <= 4'd0;
                  end else cnt <= nxt;
                  default: begin
                     st <= RELEASED;
                     cnt <= 4'd0;
                  end
               endcase
         end
   end
   always_ff @(posedge CLK or negedge RSTN)
      if (!RSTN) begin
         value <= INIT;
         D13 <= 1'b0;
      end else begin
         value <= press == 2'b01 ? value + 8'd1 : press == 2'b10 ? value - 8'd1 : value;
         D13 <= |held;
      end
endmodule

// File: tb/tb_button_counter.sv
// tb_button_counter: directed and random button stimulus against a level/run-length debounce model.
module tb_button_counter;
   localparam int N = 1;
   localparam int DB = 3;
   localparam int P = 1 << N;
   logic clk = 1'b0, rstn = 1'b0, sw1 = 1'b0, sw2 = 1'b0;
   logic l0, l1, l2, l3, l4, l5, l6, l7, d13;
   logic [7:0] leds;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   assign leds = {l7, l6, l5, l4, l3, l2, l1, l0};

   button_counter #(.N(N), .DB_SAMPLES(DB), .INIT(8'h00)) dut (
      .CLK(clk), .RSTN(rstn), .SW1(sw1), .SW2(sw2),
      .LED0(l0), .LED1(l1), .LED2(l2), .LED3(l3),
      .LED4(l4), .LED5(l5), .LED6(l6), .LED7(l7), .D13(d13));

   // Reference: each button keeps an accepted level and a run of ticks disagreeing with it;
   // a run of DB flips the level, and a flip to 1 is a press. The button counts as
   // "pressed" only while its level is 1 and no release run is in progress.
   logic [1:0] sh [2];
   logic [1:0] lvl, ev, pins;
   int run [2];
   int k;
   logic [7:0] m_val;
   logic m_d13;
   assign pins = {sw2, sw1};
   always @(posedge clk or negedge rstn)
      if (!rstn) begin
         k <= 0; lvl <= 2'b00; ev <= 2'b00; run[0] <= 0; run[1] <= 0;
         sh[0] <= 2'b00; sh[1] <= 2'b00; m_val <= 8'h00; m_d13 <= 1'b0;
      end else begin
         k <= k + 1;
         ev <= 2'b00;
         m_d13 <= (lvl[0] && run[0] == 0) || (lvl[1] && run[1] == 0);
         m_val <= ev == 2'b01 ? m_val + 8'd1 : ev == 2'b10 ? m_val - 8'd1 : m_val;
         for (int b = 0; b < 2; b++) begin
            sh[b] <= {sh[b][0], pins[b]};
            if (k % P == P - 1) begin
               if (sh[b][1] == lvl[b]) run[b] <= 0;
               else if (run[b] + 1 == DB) begin
                  lvl[b] <= !lvl[b];
                  run[b] <= 0;
                  ev[b] <= !lvl[b];
               end else run[b] <= run[b] + 1;
            end
         end
      end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("model_leds", leds, m_val);
         chk("model_d13", {7'd0, d13}, {7'd0, m_d13});
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      step(4);
      chk("reset_leds", leds, 8'h00);
      chk("reset_d13", {7'd0, d13}, 8'h00);
      rstn = 1'b1;
   endtask

   task automatic press(input int b, input int hi, input int lo);
      if (b == 0) sw1 = 1'b1; else sw2 = 1'b1;
      step(hi);
      if (b == 0) sw1 = 1'b0; else sw2 = 1'b0;
      step(lo);
   endtask

   initial begin
      int lat;
      // reset and idle
      step(10);
      chk("reset_leds", leds, 8'h00);
      chk("reset_d13", {7'd0, d13}, 8'h00);
      rstn = 1'b1;
      step(100);
      chk("idle_leds", leds, 8'h00);
      // single press with latency measured from the first edge that samples the pin
      sw1 = 1'b1;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         if (lat < 0 && leds != 8'h00) lat = i - 1;
      end
      chk("latency_ok", {7'd0, (lat >= 7 && lat <= 8)}, 8'h01);
      chk("single_leds", leds, 8'h01);
      chk("single_d13_held", {7'd0, d13}, 8'h01);
      step(20);
      sw1 = 1'b0;
      step(20);
      chk("single_d13_rel", {7'd0, d13}, 8'h00);
      chk("single_after", leds, 8'h01);
      // bounce rejection
      do_reset();
      for (int i = 0; i < 5; i++) press(0, 3, 3);
      chk("bounce_none", leds, 8'h00);
      press(0, 20, 20);
      chk("bounce_one", leds, 8'h01);
      press(0, 3, 20);
      chk("glitch", leds, 8'h01);
      // wrap both ways
      do_reset();
      for (int i = 0; i < 256; i++) press(0, 10, 10);
      chk("wrap_up", leds, 8'h00);
      press(1, 10, 10);
      chk("wrap_down", leds, 8'hFF);
      // simultaneous presses cancel
      do_reset();
      for (int i = 0; i < 5; i++) press(0, 10, 10);
      chk("pre_sim", leds, 8'h05);
      sw1 = 1'b1;
      sw2 = 1'b1;
      step(40);
      chk("sim_leds", leds, 8'h05);
      chk("sim_d13", {7'd0, d13}, 8'h01);
      sw1 = 1'b0;
      sw2 = 1'b0;
      step(20);
      chk("sim_after", leds, 8'h05);
      // reset while PRESSING, button still held
      do_reset();
      sw1 = 1'b1;
      step(5);
      rstn = 1'b0;
      step(4);
      chk("midrst_leds", leds, 8'h00);
      chk("midrst_d13", {7'd0, d13}, 8'h00);
      rstn = 1'b1;
      step(20);
      chk("midrst_after", leds, 8'h01);
      sw1 = 1'b0;
      step(20);
      // random button activity against the model
      do_reset();
      for (int i = 0; i < 120; i++) begin
         sw1 = 1'($urandom_range(0, 1));
         sw2 = 1'($urandom_range(0, 1));
         step($urandom_range(1, 12));
      end
      sw1 = 1'b0;
      sw2 = 1'b0;
      step(30);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/button_counter.md
Name: button_counter

Overview:
- Input-side companion to the free-running 8-bit LED counter: instead of the counter driving the LEDs by itself, user pushbuttons drive it.
- SW1 and SW2 are synchronised, debounced on a prescaled sample tick and edge-detected. Each clean press increments (SW1) or decrements (SW2) an 8-bit value shown on LED0..LED7.
- Top-level block for the icezum board. Parameter N shortens the prescaler for simulation.

Parameters:
- N, 16, prescaler width; debounce sample tick every 2^N CLK cycles (N=1 in simulation).
- DB_SAMPLES, 4, consecutive ticks with a changed level required to accept a level change (range 1..15).
- INIT, 8'h00, counter value after reset.

Ports:
- CLK  input  1  system clock (12 MHz on board).
- RSTN  input  1  asynchronous active-low reset.
- SW1  input  1  pushbutton, active-high, asynchronous to CLK; increment.
- SW2  input  1  pushbutton, active-high, asynchronous to CLK; decrement.
- LED0..LED7  output  1 each  counter value, LED0 = bit 0.
- D13  output  1  high while either debounced button is in state PRESSED.

Behaviour:
- Reset: asynchronous assert, synchronous-to-CLK release. While RSTN=0:
  - counter = INIT, so LED7..LED0 = INIT.
  - D13 = 0.
  - Prescaler, synchronisers, debounce counters and FSMs cleared; FSMs in RELEASED.
- Synchroniser: 2 flops per button, reset to 0. swX_s lags the pin by 2 CLK.
- Prescaler:
  - N-bit up counter.
  - tick = 1 for exactly one cycle when the prescaler equals 2^N-1; it then wraps to 0.
  - First tick occurs 2^N cycles after reset release.
- Debounce FSM, one per button:
  - States: RELEASED, PRESSING, PRESSED, RELEASING.
  - A 4-bit cnt is used only in PRESSING and RELEASING. State and cnt change only on tick cycles.
  - RELEASED: on tick with swX_s=1, go to PRESSING with cnt=1; if DB_SAMPLES=1, go directly to PRESSED.
  - PRESSING, tick with swX_s=1: cnt+1. When cnt+1 = DB_SAMPLES, go to PRESSED.
  - PRESSING, tick with swX_s=0: return to RELEASED, cnt=0. Glitch rejected; no event.
  - PRESSED: mirror of RELEASED, going to RELEASING on tick with swX_s=0.
  - RELEASING: mirror of PRESSING; goes to RELEASED after DB_SAMPLES ticks, or back to PRESSED on a tick with swX_s=1.
  - Non-tick cycles: state and cnt hold.
- Event generation:
  - press_X pulses 1 cycle on the transition into PRESSED.
  - No event on release. No auto-repeat while held.
- Counter update:
  - Registered on the cycle after press_X, so LEDs change 1 cycle after the FSM enters PRESSED.
  - Up only: +1, wraps 8'hFF -> 8'h00.
  - Down only: -1, wraps 8'h00 -> 8'hFF.
  - Up and down in the same cycle: no change; both events are consumed.
- D13: registered; equals (FSM1==PRESSED) OR (FSM2==PRESSED), 1 cycle after the state.
- Latency, pin rise to LED change, stable input:
  - 2 (sync) + wait to next tick + (DB_SAMPLES-1)·2^N + 1 cycles.
  - With N=1, DB_SAMPLES=3: 7 or 8 cycles depending on prescaler phase.
- Reset mid-operation: FSMs return to RELEASED immediately.
  - A button held across reset release counts as one fresh press once debounced.
  - No counter change while RSTN=0.
- Counter value changes only via press events, never spontaneously.

Test Plan:
- Reset: drive RSTN=0 with SW1=SW2=0 -> LEDs=8'h00, D13=0 for the whole reset. Release, idle 100 cycles -> LEDs remain 8'h00.
- Single press (N=1, DB_SAMPLES=3): raise SW1 for 40 cycles, then release.
  - Exactly one increment, LEDs=8'h01, within 8 cycles of the rise.
  - D13=1 while PRESSED; D13 returns to 0 after the release is debounced.
  - No further change after release.
- Bounce rejection: SW1 pulses high for 3 cycles, low for 3 cycles, repeated 5 times, then high for 20 cycles -> exactly one increment (LEDs=8'h01). A lone 3-cycle glitch gives no increment.
- Wrap: 256 clean SW1 presses from 8'h00 -> LEDs=8'h00. Then one SW2 press -> LEDs=8'hFF.
- Simultaneous: SW1 and SW2 raised on the same cycle and held 40 cycles from LEDs=8'h05 -> LEDs stay 8'h05, D13=1.
- Reset mid-press: SW1 held, RSTN pulsed low while the FSM is in PRESSING, then SW1 kept high -> LEDs=INIT during reset, then one increment after DB_SAMPLES ticks (LEDs=8'h01).
